spi_flash_master: RTL and testbench
===================================

// Module: spi_flash_master
// PURPOSE
//  Byte-wide SPI master (mode 0, MSB first) on the j1a IO bus. Replaces
//  bit-banged flash access through misc.out.
//  Driven by the registered IO strobes/data (io_wr_, io_rd_, dout_) decoded in
//  top; drives flash SCK/MOSI/CS, samples MISO; status/data feed io_din.
// PARAMETERS
//  DIV   2   SCK half-period in clk cycles (>=1); SCK = clk/(2*DIV)
// PORTS
//  clk        in   1  system clock; all state updates on posedge
//  reset      in   1  synchronous, active-high reset
//  wr         in   1  1-cycle strobe: start transfer of wd
//  wd         in   8  transmit byte, sampled when wr accepted
//  cs_wr      in   1  1-cycle strobe: load cs_n from cs_d
//  cs_d       in   1  new chip-select level (1 = deselected)
//  rd         in   1  1-cycle strobe: CPU read of rd_data, clears rx_valid
//  rd_data    out  8  last received byte
//  rx_valid   out  1  set when a byte completes, cleared by rd
//  busy       out  1  transfer in progress
//  sck        out  1  SPI clock, idle low
//  mosi       out  1  SPI data out
//  miso       in   1  SPI data in (already synchronous to clk)
//  cs_n       out  1  flash chip select, active low
// BEHAVIOUR
//  Reset: busy=0, sck=0, mosi=0, cs_n=1, rx_valid=0, rd_data=8'h00,
//   state=IDLE, bit count=0, divider=0. Reset mid-transfer aborts at once.
//   No partial byte is kept.
//  States: IDLE, LO (sck=0), HI (sck=1). Divider counts 0..DIV-1 per phase.
//  IDLE: wr=1 at edge T loads shift reg from wd and sets bit count=7.
//   At T+1: busy=1, sck=0, mosi=wd[7]; go to LO.
//  LO: on the last divider cycle, sck<=1 and miso is captured into shift
//   reg bit 0; go to HI.
//  HI: on the last divider cycle, sck<=0.
//   bit count>0: shift left, mosi<=next bit, count-1, go to LO.
//   bit count=0: rd_data<=shifted byte, rx_valid<=1, busy<=0, mosi<=0,
//   go to IDLE.
//  Latency: busy high exactly 16*DIV cycles. rd_data/rx_valid update on the
//   same edge busy falls. A new wr may be accepted on that edge's next cycle.
//  wr while busy=1: ignored; no queueing, no error flag.
//  cs_wr: cs_n<=cs_d next edge when busy=0. Ignored when busy=1, so a byte
//   frame cannot be cut. CS is software-controlled: multi-byte commands keep
//   cs_n low across transfers.
//  wr and cs_wr in the same IDLE cycle: both take effect. cs_n changes on
//   the same edge busy rises. Software normally asserts CS first.
//  rd same cycle as completion: completion wins, rx_valid=1. rd otherwise
//   clears rx_valid next edge; rd_data is unchanged by rd.
//  sck never glitches: it changes only at phase ends and is low in IDLE.
// TESTING
//  1 Reset: hold reset 2 cycles mid-transfer -> next cycle sck=0, cs_n=1,
//    busy=0, rx_valid=0.
//  2 DIV=2, slave model echoes 8'hA5 while wd=8'h3C -> mosi bits 0,0,1,1,
//    1,1,0,0 on sck rises. busy high 32 cycles. rd_data=8'hA5, rx_valid=1.
//  3 wr 8'hFF issued 5 cycles into a transfer of 8'h00 -> ignored; mosi
//    stays 0 all 8 bits; exactly 8 sck rises.
//  4 cs_wr cs_d=0, then 3 back-to-back wr (9F,00,00), then cs_wr cs_d=1 ->
//    cs_n low across 24 sck pulses. cs_wr while busy leaves cs_n low.
//  5 rd on the completion cycle -> rx_valid=1 after. rd one cycle later ->
//    rx_valid=0, rd_data held.
//  6 DIV=1 -> busy 16 cycles, sck period 2 clks, data as in test 2.

Source files
------------

// File: rtl/spi_flash_master.sv
// spi_flash_master: byte-wide SPI master (mode 0, MSB first) for the j1a IO bus.
// Shifts one byte out on mosi while sampling miso. Each transfer raises busy
// for exactly 16*DIV clk cycles. Chip select is a software-controlled level
// and can only be changed while idle.
//
// Parameters:
//   DIV       SCK half-period in clk cycles (>=1); SCK = clk/(2*DIV)
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   wr        in   1-cycle strobe: start transfer of wd (ignored while busy)
//   wd        in   [7:0] transmit byte, sampled when wr is accepted
//   cs_wr     in   1-cycle strobe: load cs_n from cs_d (ignored while busy)
//   cs_d      in   new chip-select level (1 = deselected)
//   rd        in   1-cycle strobe: CPU read, clears rx_valid
//   rd_data   out  [7:0] last received byte
//   rx_valid  out  set on byte completion, cleared by rd
//   busy      out  transfer in progress
//   sck       out  SPI clock, idle low
//   mosi      out  SPI data out
//   miso      in   SPI data in (synchronous to clk)
//   cs_n      out  flash chip select, active low
module spi_flash_master #(
   parameter int unsigned DIV = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr,
   input  logic [7:0] wd,
   input  logic       cs_wr,
   input  logic       cs_d,
   input  logic       rd,
   output logic [7:0] rd_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       sck,
   output logic       mosi,
   input  logic       miso,
   output logic       cs_n
);

   localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LO,
      ST_HI
   } state_t;

   state_t        r_state,    w_state;
   logic [DW-1:0] r_div,      w_div;
   logic [2:0]    r_cnt,      w_cnt;
   logic [7:0]    r_tx,       w_tx;
   logic [7:0]    r_rx,       w_rx;
   logic          r_sck,      w_sck;
   logic          r_mosi,     w_mosi;
   logic          r_busy,     w_busy;
   logic          r_cs_n,     w_cs_n;
   logic [7:0]    r_rd_data,  w_rd_data;
   logic          r_rx_valid, w_rx_valid;
   logic          w_phase_end;

   assign w_phase_end = (r_div == DIV_LAST);

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_div      <= '0;
         r_cnt      <= 3'd0;
         r_tx       <= 8'h00;
         r_rx       <= 8'h00;
         r_sck      <= 1'b0;
         r_mosi     <= 1'b0;
         r_busy     <= 1'b0;
         r_cs_n     <= 1'b1;
         r_rd_data  <= 8'h00;
         r_rx_valid <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_div      <= w_div;
         r_cnt      <= w_cnt;
         r_tx       <= w_tx;
         r_rx       <= w_rx;
         r_sck      <= w_sck;
         r_mosi     <= w_mosi;
         r_busy     <= w_busy;
         r_cs_n     <= w_cs_n;
         r_rd_data  <= w_rd_data;
         r_rx_valid <= w_rx_valid;
      end
   end

   // Next-state and output logic
   always_comb begin
      w_state    = r_state;
      w_div      = r_div;
      w_cnt      = r_cnt;
      w_tx       = r_tx;
      w_rx       = r_rx;
      w_sck      = r_sck;
      w_mosi     = r_mosi;
      w_busy     = r_busy;
      w_cs_n     = r_cs_n;
      w_rd_data  = r_rd_data;
      // A read clears rx_valid, but a completion on the same edge overrides it below
      w_rx_valid = r_rx_valid & ~rd;

      // Chip select is frozen during a byte so a frame cannot be cut
      if (cs_wr && !r_busy) begin
         w_cs_n = cs_d;
      end

      case (r_state)
         ST_IDLE: begin
            if (wr) begin
               w_tx    = wd;
               w_cnt   = 3'd7;
               w_busy  = 1'b1;
               w_sck   = 1'b0;
               w_mosi  = wd[7];
               w_div   = '0;
               w_state = ST_LO;
            end
         end
         ST_LO: begin
            if (w_phase_end) begin
               w_div   = '0;
               w_sck   = 1'b1;
               // Receive bits go to their own register so tx bit 0 survives until sent
               w_rx    = {r_rx[6:0], miso};
               w_state = ST_HI;
            end else begin
               w_div = r_div + DW'(1);
            end
         end
         ST_HI: begin
            if (w_phase_end) begin
               w_div = '0;
               w_sck = 1'b0;
               if (r_cnt != 3'd0) begin
                  w_tx    = {r_tx[6:0], 1'b0};
                  w_mosi  = r_tx[6];
                  w_cnt   = r_cnt - 3'd1;
                  w_state = ST_LO;
               end else begin
                  w_rd_data  = r_rx;
                  w_rx_valid = 1'b1;
                  w_busy     = 1'b0;
                  w_mosi     = 1'b0;
                  w_state    = ST_IDLE;
               end
            end else begin
               w_div = r_div + DW'(1);
            end
         end
         default: begin
            w_state = ST_IDLE;
         end
      endcase
   end

   assign rd_data  = r_rd_data;
   assign rx_valid = r_rx_valid;
   assign busy     = r_busy;
   assign sck      = r_sck;
   assign mosi     = r_mosi;
   assign cs_n     = r_cs_n;

endmodule

// File: tb/tb_spi_flash_master.sv
// Testbench for spi_flash_master: a DIV=2 and a DIV=1 instance share the CPU-side
// strobes. Each instance has its own slave model driving miso. Expected values
// come from the transfer rules: mosi carries wd MSB first, and rd_data equals the
// slave byte. Busy lasts 16*DIV cycles, there are 8 sck rises, and sck is high
// for 8*DIV cycles.
module tb_spi_flash_master;

   logic       clk = 1'b0;
   logic       reset, wr, cs_wr, cs_d, rd;
   logic [7:0] wd;
   logic       miso1, miso2;
   logic [7:0] rd_data1, rd_data2;
   logic       rx_valid1, rx_valid2, busy1, busy2, sck1, sck2, mosi1, mosi2, cs_n1, cs_n2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   spi_flash_master #(.DIV(2)) dut2 (
      .clk(clk), .reset(reset), .wr(wr), .wd(wd), .cs_wr(cs_wr), .cs_d(cs_d), .rd(rd),
      .rd_data(rd_data2), .rx_valid(rx_valid2), .busy(busy2), .sck(sck2), .mosi(mosi2),
      .miso(miso2), .cs_n(cs_n2)
   );

   spi_flash_master #(.DIV(1)) dut1 (
      .clk(clk), .reset(reset), .wr(wr), .wd(wd), .cs_wr(cs_wr), .cs_d(cs_d), .rd(rd),
      .rd_data(rd_data1), .rx_valid(rx_valid1), .busy(busy1), .sck(sck1), .mosi(mosi1),
      .miso(miso1), .cs_n(cs_n1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // All tasks are entered just after a falling clock edge
   task automatic cs_pulse(input logic val);
      cs_wr = 1'b1;
      cs_d  = val;
      @(negedge clk);
      cs_wr = 1'b0;
   endtask

   task automatic rd_pulse();
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
   endtask

   // One byte on both instances; optional disturbances are issued mid-transfer
   task automatic do_xfer(input string name, input logic [7:0] tx, input logic [7:0] s1,
                          input logic [7:0] s2, input int inj_wr_n, input bit inj_rd,
                          input int inj_cs_n, input bit cs_with_wr, input logic exp_cs_n);
      int b1 = 0, b2 = 0, r1 = 0, r2 = 0, h1 = 0, h2 = 0, cs_bad = 0;
      logic [7:0] m1 = 8'h00, m2 = 8'h00;
      logic p1 = 1'b0, p2 = 1'b0;
      bit done = 1'b0;
      miso1 = s1[7];
      miso2 = s2[7];
      wr = 1'b1;
      wd = tx;
      if (cs_with_wr) begin
         cs_wr = 1'b1;
         cs_d  = exp_cs_n;
      end
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         wr = 1'b0;
         if (n == inj_wr_n) begin
            wr = 1'b1;
            wd = 8'hFF;
         end
         rd    = inj_rd && (n == 32);
         cs_wr = (n == inj_cs_n);
         if (n == inj_cs_n) cs_d = 1'b1;
         if (busy1) b1++;
         if (busy2) b2++;
         if (sck1) h1++;
         if (sck2) h2++;
         if (sck1 && !p1) begin r1++; m1 = {m1[6:0], mosi1}; end
         if (sck2 && !p2) begin r2++; m2 = {m2[6:0], mosi2}; end
         p1 = sck1;
         p2 = sck2;
         if (r1 < 8) miso1 = s1[3'(7 - r1)];
         if (r2 < 8) miso2 = s2[3'(7 - r2)];
         if (cs_n1 !== exp_cs_n || cs_n2 !== exp_cs_n) cs_bad++;
         if (!busy1 && !busy2) begin
            done = 1'b1;
            break;
         end
      end
      rd    = 1'b0;
      cs_wr = 1'b0;
      wr    = 1'b0;
      check({name, ".done"},    32'(done), 32'd1);
      check({name, ".busy1"},   32'(b1), 32'd16);
      check({name, ".busy2"},   32'(b2), 32'd32);
      check({name, ".rises1"},  32'(r1), 32'd8);
      check({name, ".rises2"},  32'(r2), 32'd8);
      check({name, ".schi1"},   32'(h1), 32'd8);
      check({name, ".schi2"},   32'(h2), 32'd16);
      check({name, ".mosi1"},   32'(m1), 32'(tx));
      check({name, ".mosi2"},   32'(m2), 32'(tx));
      check({name, ".rdata1"},  32'(rd_data1), 32'(s1));
      check({name, ".rdata2"},  32'(rd_data2), 32'(s2));
      check({name, ".rxv1"},    32'(rx_valid1), 32'(!inj_rd));
      check({name, ".rxv2"},    32'(rx_valid2), 32'd1);
      check({name, ".cs_hold"}, 32'(cs_bad), 32'd0);
   endtask

   initial begin
      logic [7:0] tx, s1, s2;
      reset = 1'b1; wr = 1'b0; wd = 8'h00; cs_wr = 1'b0; cs_d = 1'b1; rd = 1'b0;
      miso1 = 1'b0; miso2 = 1'b0;
      repeat (3) @(negedge clk);
      check("rst.sck",   32'({sck1, sck2}),   32'd0);
      check("rst.mosi",  32'({mosi1, mosi2}), 32'd0);
      check("rst.cs_n",  32'({cs_n1, cs_n2}), 32'd3);
      check("rst.busy",  32'({busy1, busy2}), 32'd0);
      check("rst.rxv",   32'({rx_valid1, rx_valid2}), 32'd0);
      check("rst.rdata", 32'({rd_data1, rd_data2}), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Basic byte with CS asserted first
      cs_pulse(1'b0);
      check("t2.cs_low", 32'({cs_n1, cs_n2}), 32'd0);
      do_xfer("t2", 8'h3C, 8'hA5, 8'hA5, 0, 1'b0, 0, 1'b0, 1'b0);

      // wr while busy is ignored
      do_xfer("t3", 8'h00, 8'h5A, 8'hC3, 5, 1'b0, 0, 1'b0, 1'b0);

      // Three back-to-back bytes under one CS; cs_wr mid-byte is ignored
      cs_pulse(1'b1);
      check("t4.cs_hi0", 32'({cs_n1, cs_n2}), 32'd3);
      cs_pulse(1'b0);
      do_xfer("t4a", 8'h9F, 8'hEF, 8'hEF, 0, 1'b0, 0,  1'b0, 1'b0);
      do_xfer("t4b", 8'h00, 8'h40, 8'h40, 0, 1'b0, 10, 1'b0, 1'b0);
      do_xfer("t4c", 8'h00, 8'h17, 8'h17, 0, 1'b0, 0,  1'b0, 1'b0);
      cs_pulse(1'b1);
      check("t4.cs_hi1", 32'({cs_n1, cs_n2}), 32'd3);

      // cs_wr and wr in the same idle cycle both take effect
      do_xfer("t4d", 8'h81, 8'h7E, 8'h18, 0, 1'b0, 0, 1'b1, 1'b0);

      // rd on the completion edge loses; a later rd clears rx_valid only
      do_xfer("t5", 8'h96, 8'h33, 8'hD2, 0, 1'b1, 0, 1'b0, 1'b0);
      rd_pulse();
      check("t5.rxv_clr",  32'(rx_valid2), 32'd0);
      check("t5.rd_hold",  32'(rd_data2), 32'hD2);

      // Randomized bytes, with an occasional read afterwards
      for (int i = 0; i < 10; i++) begin
         tx = 8'($urandom);
         s1 = 8'($urandom);
         s2 = 8'($urandom);
         do_xfer("rnd", tx, s1, s2, 0, 1'b0, 0, 1'b0, 1'b0);
         if ($urandom_range(1, 0) == 1) begin
            rd_pulse();
            check("rnd.rxv_clr", 32'({rx_valid1, rx_valid2}), 32'd0);
            check("rnd.rd_hold", 32'({rd_data1, rd_data2}), 32'({s1, s2}));
         end
      end

      // Reset held 2 cycles mid-transfer aborts everything
      wr = 1'b1;
      wd = 8'h5A;
      @(negedge clk);
      wr = 1'b0;
      repeat (9) @(negedge clk);
      check("t1.busy_pre", 32'(busy2), 32'd1);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("t1.sck",   32'({sck1, sck2}),   32'd0);
      check("t1.cs_n",  32'({cs_n1, cs_n2}), 32'd3);
      check("t1.busy",  32'({busy1, busy2}), 32'd0);
      check("t1.rxv",   32'({rx_valid1, rx_valid2}), 32'd0);
      check("t1.rdata", 32'({rd_data1, rd_data2}), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
